// File: rtl/riscv_regfile_sb.sv
// riscv_regfile_sb
//   Integer register file with a write-pending scoreboard. It sits between
//   decode/issue, which reads operands and checks busy bits, and writeback.
//   Register x0 always reads zero and is never marked pending.
//
//   Optional feature macro: REGFILE_BYPASS_EN
//     When defined, each read port forwards same-cycle writeback data and
//     reports the register as not busy. The debug port is never bypassed.
//
//   Parameters
//     XLEN   register width in bits
//     NREGS  register count (16 or 32); AW = $clog2(NREGS)
//     NREAD  number of combinational read ports (1..4)
//
//   Ports
//     clk_in           system clock
//     rst_in           synchronous active-high reset
//     raddr_in         read addresses, port k at [k*AW +: AW]
//     rdata_out        read data, port k at [k*XLEN +: XLEN]
//     rbusy_out        port k's register has a pending write
//     wr_valid_in      writeback valid
//     wr_addr_in       writeback destination
//     wr_data_in       writeback data
//     issue_valid_in   an instruction with a destination issues
//     issue_addr_in    destination to mark pending
//     issue_ready_out  issue is accepted this cycle
//     flush_in         clear all pending marks
//     busy_count_out   number of pending registers
//     reg_debug_in     debug read address
//     reg_debug_out    debug read data (stored state only)
module riscv_regfile_sb #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NREAD = 2,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic [NREAD*AW-1:0]   raddr_in,
   output logic [NREAD*XLEN-1:0] rdata_out,
   output logic [NREAD-1:0]      rbusy_out,
   input  logic                  wr_valid_in,
   input  logic [AW-1:0]         wr_addr_in,
   input  logic [XLEN-1:0]       wr_data_in,
   input  logic                  issue_valid_in,
   input  logic [AW-1:0]         issue_addr_in,
   output logic                  issue_ready_out,
   input  logic                  flush_in,
   output logic [AW-1:0]         busy_count_out,
   input  logic [AW-1:0]         reg_debug_in,
   output logic [XLEN-1:0]       reg_debug_out
);

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busy_next;
   logic             wr_en;
   logic             issue_accept;

   // x0 is hard-wired: writes to it are discarded.
   assign wr_en = wr_valid_in && (wr_addr_in != '0);

   // A writeback to the destination in the same cycle frees it, so the issue
   // may proceed; x0 never blocks.
   assign issue_ready_out = !busy[issue_addr_in]
                          || (wr_valid_in && (wr_addr_in == issue_addr_in))
                          || (issue_addr_in == '0);

   assign issue_accept = issue_valid_in && issue_ready_out && !flush_in
                       && (issue_addr_in != '0);

   // Scoreboard update: the writeback clear is applied first so that a
   // same-cycle issue to that register wins and leaves it pending.
   // NOTE: busy_next gets a full default before any conditional update, so
   // no latch is inferred.
   always_comb begin
      busy_next = busy;
      if (wr_en) busy_next[wr_addr_in] = 1'b0;
      if (flush_in) begin
         busy_next = '0;
      end else if (issue_accept) begin
         busy_next[issue_addr_in] = 1'b1;
      end
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         // NOTE: the array is reset explicitly because software may read any
         // register before writing it and must see zero.
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         busy <= '0;
      end else begin
         if (wr_en) regs[wr_addr_in] <= wr_data_in;
         busy <= busy_next;
      end
   end

   // Pending count of the registered busy vector; bit 0 is never set, so the
   // count tops out at NREGS-1 and fits in AW bits.
   always_comb begin
      busy_count_out = '0;
      for (int i = 1; i < NREGS; i++) begin
         busy_count_out = busy_count_out + AW'(busy[i]);
      end
   end

   genvar k;
   generate
      for (k = 0; k < NREAD; k++) begin : g_rd
         logic [AW-1:0]   ra;
         logic [XLEN-1:0] stored;

         assign ra     = raddr_in[k*AW +: AW];
         assign stored = (ra == '0) ? '0 : regs[ra];

`ifdef REGFILE_BYPASS_EN
         logic hit;
         assign hit = wr_valid_in && (wr_addr_in == ra) && (ra != '0);
         assign rdata_out[k*XLEN +: XLEN] = hit ? wr_data_in : stored;
         assign rbusy_out[k]              = busy[ra] && !hit;
`else
         assign rdata_out[k*XLEN +: XLEN] = stored;
         assign rbusy_out[k]              = busy[ra];
`endif
      end
   endgenerate

   assign reg_debug_out = (reg_debug_in == '0) ? '0 : regs[reg_debug_in];

endmodule

// File: tb/tb_riscv_regfile_sb.sv
module tb_riscv_regfile_sb;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NREAD = 2;
   localparam int AW    = 5;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic                  clk_in = 1'b0;
   logic                  rst_in;
   logic [NREAD*AW-1:0]   raddr_in;
   logic [NREAD*XLEN-1:0] rdata_out;
   logic [NREAD-1:0]      rbusy_out;
   logic                  wr_valid_in;
   logic [AW-1:0]         wr_addr_in;
   logic [XLEN-1:0]       wr_data_in;
   logic                  issue_valid_in;
   logic [AW-1:0]         issue_addr_in;
   logic                  issue_ready_out;
   logic                  flush_in;
   logic [AW-1:0]         busy_count_out;
   logic [AW-1:0]         reg_debug_in;
   logic [XLEN-1:0]       reg_debug_out;

   riscv_regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .raddr_in        (raddr_in),
      .rdata_out       (rdata_out),
      .rbusy_out       (rbusy_out),
      .wr_valid_in     (wr_valid_in),
      .wr_addr_in      (wr_addr_in),
      .wr_data_in      (wr_data_in),
      .issue_valid_in  (issue_valid_in),
      .issue_addr_in   (issue_addr_in),
      .issue_ready_out (issue_ready_out),
      .flush_in        (flush_in),
      .busy_count_out  (busy_count_out),
      .reg_debug_in    (reg_debug_in),
      .reg_debug_out   (reg_debug_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      string           name;
      logic [XLEN-1:0] rd0;
      logic [XLEN-1:0] rd1;
      logic            rb0;
      logic            rb1;
      logic            ready;
      logic [AW-1:0]   count;
      logic [XLEN-1:0] dbg;
   } exp_t;

   exp_t exp_q[$];
   logic obs = 1'b0;
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string nm, input string fld,
                        input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, fld, act, exp);
      else
         n_pass++;
   endtask

   // Monitor: each observed cycle pops one expectation and compares it with
   // the DUT outputs away from the active edge.
   always @(negedge clk_in) begin
      if (obs) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard: observation with empty queue");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.name, "rdata0", rdata_out[0 +: XLEN], e.rd0);
            check(e.name, "rdata1", rdata_out[XLEN +: XLEN], e.rd1);
            check(e.name, "rbusy0", XLEN'(rbusy_out[0]), XLEN'(e.rb0));
            check(e.name, "rbusy1", XLEN'(rbusy_out[1]), XLEN'(e.rb1));
            check(e.name, "ready", XLEN'(issue_ready_out), XLEN'(e.ready));
            check(e.name, "count", XLEN'(busy_count_out), XLEN'(e.count));
            check(e.name, "debug", reg_debug_out, e.dbg);
         end
      end
   end

   task automatic drive(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                        input logic wv, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                        input logic iv, input logic [AW-1:0] ia, input logic fl,
                        input logic [AW-1:0] dbg);
      raddr_in       = {ra1, ra0};
      wr_valid_in    = wv;
      wr_addr_in     = wa;
      wr_data_in     = wd;
      issue_valid_in = iv;
      issue_addr_in  = ia;
      flush_in       = fl;
      reg_debug_in   = dbg;
   endtask

   task automatic expect_cyc(input string nm,
                             input logic [XLEN-1:0] rd0, input logic [XLEN-1:0] rd1,
                             input logic rb0, input logic rb1, input logic rdy,
                             input logic [AW-1:0] cnt, input logic [XLEN-1:0] dbg);
      exp_t e;
      e.name = nm; e.rd0 = rd0; e.rd1 = rd1; e.rb0 = rb0; e.rb1 = rb1;
      e.ready = rdy; e.count = cnt; e.dbg = dbg;
      exp_q.push_back(e);
      obs = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
      obs = 1'b0;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst_in = 1'b1;
      // Activity during reset must be ignored.
      drive(5, 7, 1, 5, 32'h1111_2222, 1, 7, 0, 5);
      tick();
      tick();
      rst_in = 1'b0;

      // Every address reads zero and not busy after reset.
      for (int a = 0; a < NREGS; a++) begin
         drive(AW'(a), AW'(NREGS - 1 - a), 0, 0, 0, 0, AW'(a), 0, AW'(a));
         expect_cyc($sformatf("reset_a%0d", a), 0, 0, 0, 0, 1, 0, 0);
         tick();
      end

      // Write x5; bypass decides same-cycle visibility.
      drive(5, 5, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 5);
      expect_cyc("wr_x5_same", BYP ? 32'hDEAD_BEEF : 0, BYP ? 32'hDEAD_BEEF : 0,
                 0, 0, 1, 0, 0);
      tick();
      drive(5, 0, 1, 0, 32'h1234, 0, 0, 0, 5);
      expect_cyc("wr_x5_next", 32'hDEAD_BEEF, 0, 0, 0, 1, 0, 32'hDEAD_BEEF);
      tick();
      drive(0, 5, 0, 0, 0, 0, 0, 0, 0);
      expect_cyc("x0_after_wr", 0, 32'hDEAD_BEEF, 0, 0, 1, 0, 0);
      tick();

      // Issue x7, retry while busy, then writeback clears.
      drive(7, 7, 0, 0, 0, 1, 7, 0, 7);
      expect_cyc("issue_x7", 0, 0, 0, 0, 1, 0, 0);
      tick();
      drive(7, 7, 0, 0, 0, 1, 7, 0, 7);
      expect_cyc("reissue_x7", 0, 0, 1, 1, 0, 1, 0);
      tick();
      drive(7, 7, 1, 7, 32'h55, 0, 7, 0, 7);
      expect_cyc("wb_x7", BYP ? 32'h55 : 0, BYP ? 32'h55 : 0, !BYP, !BYP, 1, 1, 0);
      tick();
      idle(); raddr_in = {5'd7, 5'd7}; issue_addr_in = 7; reg_debug_in = 7;
      expect_cyc("x7_clear", 32'h55, 32'h55, 0, 0, 1, 0, 32'h55);
      tick();

      // Same-cycle write and issue to a busy register: set wins.
      drive(3, 3, 0, 0, 0, 1, 3, 0, 3);
      expect_cyc("issue_x3", 0, 0, 0, 0, 1, 0, 0);
      tick();
      drive(3, 3, 1, 3, 32'hA, 1, 3, 0, 3);
      expect_cyc("wr_issue_x3", BYP ? 32'hA : 0, BYP ? 32'hA : 0, !BYP, !BYP, 1, 1, 0);
      tick();
      drive(3, 3, 0, 0, 0, 0, 3, 0, 3);
      expect_cyc("x3_still_busy", 32'hA, 32'hA, 1, 1, 0, 1, 32'hA);
      tick();
      drive(3, 3, 1, 3, 32'hB, 0, 0, 0, 0);
      expect_cyc("wb_x3", BYP ? 32'hB : 32'hA, BYP ? 32'hB : 32'hA, !BYP, !BYP, 1, 1, 0);
      tick();

      // Issue x1, x2, x3, then flush with concurrent issue x4 and write x9.
      drive(1, 3, 0, 0, 0, 1, 1, 0, 0);
      expect_cyc("issue_x1", 0, 32'hB, 0, 0, 1, 0, 0);
      tick();
      drive(1, 2, 0, 0, 0, 1, 2, 0, 0);
      expect_cyc("issue_x2", 0, 0, 1, 0, 1, 1, 0);
      tick();
      drive(2, 3, 0, 0, 0, 1, 3, 0, 0);
      expect_cyc("issue_x3b", 0, 32'hB, 1, 0, 1, 2, 0);
      tick();
      drive(3, 9, 1, 9, 32'h99, 1, 4, 1, 0);
      expect_cyc("flush", 32'hB, BYP ? 32'h99 : 0, 1, 0, 1, 3, 0);
      tick();
      drive(4, 9, 0, 0, 0, 0, 1, 0, 9);
      expect_cyc("after_flush", 0, 32'h99, 0, 0, 1, 0, 32'h99);
      tick();

      // Bypass probe on x6: make x6 busy with old data, then write new data.
      drive(6, 6, 1, 6, 32'h1111, 1, 6, 0, 6);
      expect_cyc("x6_setup", BYP ? 32'h1111 : 0, BYP ? 32'h1111 : 0, 0, 0, 1, 0, 0);
      tick();
      drive(6, 6, 1, 6, 32'hCAFE, 0, 6, 0, 6);
      expect_cyc("x6_bypass", BYP ? 32'hCAFE : 32'h1111, BYP ? 32'hCAFE : 32'h1111,
                 !BYP, !BYP, 1, 1, 32'h1111);
      tick();
      drive(6, 6, 0, 0, 0, 0, 6, 0, 6);
      expect_cyc("x6_after", 32'hCAFE, 32'hCAFE, 0, 0, 1, 0, 32'hCAFE);
      tick();

      // Reset mid-run clears data and scoreboard and overrides traffic.
      drive(8, 8, 0, 0, 0, 1, 8, 0, 0);
      tick();
      rst_in = 1'b1;
      drive(10, 11, 1, 10, 32'h77, 1, 11, 0, 6);
      tick();
      rst_in = 1'b0;
      drive(8, 10, 0, 0, 0, 0, 8, 0, 6);
      expect_cyc("rst_mid_a", 0, 0, 0, 0, 1, 0, 0);
      tick();
      drive(11, 6, 0, 0, 0, 0, 11, 0, 5);
      expect_cyc("rst_mid_b", 0, 0, 0, 0, 1, 0, 0);
      tick();
      idle();

      // Drain: every expectation must have been consumed within a few cycles.
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
      n_checks++;
      if (exp_q.size() != 0)
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      else
         n_pass++;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/riscv_regfile_sb.md
# riscv_regfile_sb

Parametrised integer register file with an integrated write-pending scoreboard, for the pipelined core. Provides NREAD combinational read ports, one writeback port, an issue port that marks destinations pending, and a flush that drops all pending marks. Sits between decode/issue (reads and busy checks) and writeback, and exposes a debug read port for the on-board register viewer.

## Interface
Parameters:
- XLEN, 32: register width in bits.
- NREGS, 32: register count; power of two, 16 (RV32E) or 32. AW = $clog2(NREGS).
- NREAD, 2: number of read ports, 1..4.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-high reset.
- raddr_in  input  NREAD*AW  read addresses; port k at bits [k*AW +: AW].
- rdata_out  output  NREAD*XLEN  read data; port k at [k*XLEN +: XLEN].
- rbusy_out  output  NREAD  port k's register has a pending write.
- wr_valid_in  input  1  writeback valid.
- wr_addr_in  input  AW  writeback destination.
- wr_data_in  input  XLEN  writeback data.
- issue_valid_in  input  1  an instruction with a destination issues this cycle.
- issue_addr_in  input  AW  destination being marked pending.
- issue_ready_out  output  1  issue is accepted this cycle.
- flush_in  input  1  clear all pending marks.
- busy_count_out  output  AW  number of registers currently pending.
- reg_debug_in  input  AW  debug read address.
- reg_debug_out  output  XLEN  debug read data (never bypassed).

## Operation
- Storage: NREGS x XLEN array plus NREGS-bit busy vector. Register 0 reads 0 and is never busy; writes and issues to 0 are ignored (issue to 0 is always ready).
- Reads: combinational from the array and busy vector.
- Write: on wr_valid_in with wr_addr_in != 0, array[wr_addr_in] <= wr_data_in and busy[wr_addr_in] <= 0 at the clock edge. Writing a non-busy register is legal (data commits, busy stays 0).
- Issue: issue_ready_out = !busy[issue_addr_in] | (wr_valid_in & wr_addr_in == issue_addr_in) | (issue_addr_in == 0). Accepted issue (valid & ready & !flush_in & addr != 0) sets busy[issue_addr_in].
- Same-cycle write and issue to the same register: data commits, busy ends set (the set takes priority over the clear).
- Flush: busy vector <= 0; the issue that cycle is dropped; a write that cycle still commits.
- busy_count_out: popcount of the registered busy vector, 0..NREGS-1.
- Reset: all registers 0, busy vector 0, busy_count_out 0; rbusy_out all 0; issue_ready_out 1. Reset overrides write, issue and flush that cycle.

## Timing
- Read latency: 0 cycles (combinational). Without bypass, a write is visible on rdata_out/reg_debug_out the cycle after its edge.
- Busy set/clear visible on rbusy_out and busy_count_out the cycle after the edge.
- issue_ready_out is combinational from the busy vector and the current writeback; no dependence on issue_valid_in.
- Issue to an already-busy register with no matching writeback: ready 0, no state change; the requester holds and retries.

## Configuration
- REGFILE_BYPASS_EN defined: for each read port, if wr_valid_in & wr_addr_in == raddr & raddr != 0, rdata_out returns wr_data_in and rbusy_out is 0 in the same cycle. reg_debug_out is never bypassed.
- Undefined: rdata_out/rbusy_out reflect stored state only; written data appears one cycle later.

## Test plan
- Reset, then read all ports at addresses 0..NREGS-1 -> all rdata 0, rbusy 0, busy_count 0, issue_ready 1.
- Write 0xDEADBEEF to x5, next cycle read x5 on every port -> 0xDEADBEEF; write 0x1234 to x0 -> x0 still reads 0.
- Issue x7 -> rbusy for x7 = 1 next cycle, busy_count 1; issue x7 again -> ready 0, no change; write x7 = 0x55 -> busy clears, count 0, read 0x55.
- Same cycle: write x3 = 0xA and issue x3 while x3 is busy -> ready 1; next cycle x3 = 0xA, still busy, count unchanged.
- Issue x1, x2, x3 on consecutive cycles, then flush with a concurrent issue of x4 and write x9 = 0x99 -> count 0, x4 not busy, x9 = 0x99.
- With REGFILE_BYPASS_EN: write x6 = 0xCAFE while reading x6 -> rdata 0xCAFE and rbusy 0 in the same cycle, reg_debug_out on x6 shows the old value; without the macro -> old value until the next cycle.
